// File: rtl/cpu_out_rx_pkg.sv
// -----------------------------------------------------------------------------
// cpu_out_rx_pkg
//   Shared definitions for the cpu_out serial receiver: the deframer FSM state
//   type and the number of data bits carried by one frame.
// -----------------------------------------------------------------------------
package cpu_out_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int unsigned RX_FRAME_BITS = 8;

endpackage

// File: rtl/cpu_out_rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
//   First-word fall-through FIFO holding received bytes.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous reset, active low; empties the FIFO
//     push       write request; ignored when full unless a pop happens too
//     push_data  data written on push
//     pop        read request; ignored when empty
//     pop_data   entry at the head (don't-care while empty)
//     empty      no entries stored
//     full       DEPTH entries stored
//     count      number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = CW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_out_rx.sv
// -----------------------------------------------------------------------------
// cpu_out_rx
//   Receiver for the CPU's serial cpu_out line. Deframes 1 start bit (low),
//   8 data bits LSB first and 1 stop bit (high) into bytes, sampling mid-bit,
//   and queues them in a FIFO behind a valid/ready byte port.
//   Ports:
//     clk        rising-edge clock, shared with the CPU
//     reset      asynchronous reset, active low
//     rx         serial line driven by cpu_out (idle high)
//     out_data   byte at the FIFO head
//     out_valid  FIFO not empty
//     out_ready  consumer takes out_data when out_valid && out_ready
//     count      bytes currently queued
//     frame_err  one-cycle pulse when a stop bit was sampled low
//     overrun    one-cycle pulse when a complete byte was dropped (FIFO full)
// -----------------------------------------------------------------------------
module cpu_out_rx
    import cpu_out_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          frame_err,
    output logic          overrun
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(RX_FRAME_BITS);

    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(RX_FRAME_BITS - 1);

    rx_state_e                  state_q, state_d;
    logic [TW-1:0]              tick_q, tick_d;
    logic [BW-1:0]              bit_q, bit_d;
    logic [RX_FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                       rx_q;
    logic                       frame_err_q, frame_err_d;
    logic                       overrun_q, overrun_d;
    logic                       tick_zero;
    logic                       push_req;

    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_pop;

    assign tick_zero = (tick_q == '0);

    // State register plus datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RX_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            rx_q        <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            RX_IDLE: begin
                // Half a bit to the middle of the start bit
                if (!rx_q) begin
                    state_d = RX_START;
                    tick_d  = TICK_HALF;
                end
            end
            RX_START: begin
                if (tick_zero) begin
                    if (rx_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        tick_d  = TICK_FULL;
                        bit_d   = '0;
                    end
                end else begin
                    tick_d = tick_q - TW'(1);
                end
            end
            RX_DATA: begin
                if (tick_zero) begin
                    shreg_d = {rx_q, shreg_q[RX_FRAME_BITS-1:1]};
                    tick_d  = TICK_FULL;
                    if (bit_q == BIT_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    tick_d = tick_q - TW'(1);
                end
            end
            RX_STOP: begin
                if (tick_zero) begin
                    state_d = rx_q ? RX_IDLE : RX_WAIT_IDLE;
                end else begin
                    tick_d = tick_q - TW'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (state_q == RX_STOP && tick_zero) begin
            push_req    = rx_q;
            frame_err_d = !rx_q;
        end
        // Dropped only when full and the head is not leaving this cycle
        overrun_d = push_req && fifo_full && !fifo_pop;
    end

    assign fifo_pop  = out_ready && !fifo_empty;
    assign out_valid = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    rx_fifo #(
        .WIDTH (RX_FRAME_BITS),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg_q),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

endmodule

// File: tb/tb_cpu_out_rx.sv
// -----------------------------------------------------------------------------
// tb_cpu_out_rx
//   Scoreboard bench for cpu_out_rx: stimulus pushes the bytes it expects to
//   see into exp_q; the monitor pops and compares on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_cpu_out_rx;

    localparam int CPB = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overrun;

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            n_acc = 0;
    int            fe_cnt = 0;
    int            ov_cnt = 0;
    logic [7:0]    exp_q [$];
    logic [7:0]    mon_exp;

    cpu_out_rx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (8),
        .CW           (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (out_valid && out_ready) begin
                n_acc++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got 8'h%02h, expected no transfer", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        failures++;
                        $display("FAIL byte_order: got 8'h%02h, expected 8'h%02h", out_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        int acc0;
        int fe0;
        int ov0;

        // Reset held low for two cycles
        tick(2);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b1;
        tick(3);

        // 1: single byte, consumer ready, push latency window
        out_ready = 1'b1;
        fe0 = fe_cnt;
        exp_q.push_back(8'hA5);
        t0  = cyc;
        lat = -1;
        fork
            send(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        checks++;
        if (lat < 39 || lat > 41) begin
            failures++;
            $display("FAIL t1_latency: got %0d cycles, expected 39..41", lat);
        end
        tick(4);
        chk("t1_accepts", n_acc, 1);
        chk("t1_frame_err", fe_cnt - fe0, 0);
        drain("t1_drain", 5);
        chk("t1_valid_low", int'(out_valid), 0);

        // 2: back-to-back bytes held in the FIFO, then drained in order
        out_ready = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        tick(4);
        chk("t2_count3", int'(count), 3);
        chk("t2_head", int'(out_data), 8'h00);
        out_ready = 1'b1;
        drain("t2_drain", 20);
        tick(1);
        chk("t2_count0", int'(count), 0);

        // 3: one-cycle glitch is rejected, receiver still works afterwards
        acc0 = n_acc;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(8);
        chk("t3_no_push", n_acc - acc0, 0);
        chk("t3_count", int'(count), 0);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        drain("t3_drain", 10);

        // 4: stop bit low, line held low, then recovery
        fe0  = fe_cnt;
        acc0 = n_acc;
        send(8'h55, 1'b0);
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(CPB);
        chk("t4_frame_err", fe_cnt - fe0, 1);
        chk("t4_count", int'(count), 0);
        chk("t4_no_push", n_acc - acc0, 0);
        exp_q.push_back(8'h12);
        send(8'h12, 1'b1);
        drain("t4_drain", 10);

        // 5a: nine bytes into an eight-entry FIFO
        out_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send(8'(i), 1'b1);
        end
        tick(4);
        chk("t5_count_full", int'(count), 8);
        chk("t5_overrun", ov_cnt - ov0, 1);
        out_ready = 1'b1;
        drain("t5_drain", 30);
        tick(1);
        chk("t5_count0", int'(count), 0);

        // 5b: full FIFO with a pop on the push edge, no byte lost
        out_ready = 1'b0;
        for (int i = 8'h11; i <= 8'h18; i++) begin
            exp_q.push_back(8'(i));
            send(8'(i), 1'b1);
        end
        tick(4);
        chk("t5b_count_full", int'(count), 8);
        ov0 = ov_cnt;
        exp_q.push_back(8'h19);
        fork
            send(8'h19, 1'b1);
            begin
                tick(39);
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
            end
        join
        tick(4);
        chk("t5b_count", int'(count), 8);
        chk("t5b_overrun", ov_cnt - ov0, 0);
        chk("t5b_pending", exp_q.size(), 8);
        out_ready = 1'b1;
        drain("t5b_drain", 30);
        tick(1);
        chk("t5b_count0", int'(count), 0);

        // 6: reset in the middle of a frame flushes everything
        out_ready = 1'b0;
        send(8'h99, 1'b1);
        tick(4);
        chk("t6_count_pre", int'(count), 1);
        fork
            send(8'hC3, 1'b1);
            begin
                tick(15);
                reset = 1'b0;
                #1;
                chk("t6_valid_rst", int'(out_valid), 0);
                chk("t6_count_rst", int'(count), 0);
            end
        join
        tick(2);
        reset = 1'b1;
        tick(4);
        out_ready = 1'b1;
        acc0 = n_acc;
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        drain("t6_drain", 10);
        tick(2);
        chk("t6_accepts", n_acc - acc0, 1);
        chk("t6_count0", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
